delay_line_ctrl: RTL and testbench
==================================

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, audio sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, SRAM address width (2^14-word ring).
REQ-003 SHALL use a single clock and a synchronous, active-high reset, with ports named as follows:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following ports:
- sample_in  in  DATA_WIDTH  input audio sample.
- sample_valid  in  1  one-cycle strobe, sample_in valid.
- delay_len  in  ADDR_WIDTH  delay in samples; 0 = bypass.
- delayed_sample  out  DATA_WIDTH  delayed audio sample.
- delayed_valid  out  1  one-cycle strobe, delayed_sample valid.
- busy  out  1  high when not in IDLE.
- overrun  out  1  sticky; sample_valid arrived while busy.
- csb0  out  1  SRAM port 0 chip select, active-low.
- web0  out  1  SRAM port 0 write enable, active-low.
- addr0  out  ADDR_WIDTH  SRAM port 0 address.
- din0  out  DATA_WIDTH  SRAM port 0 write data.
- csb1  out  1  SRAM port 1 chip select, active-low.
- addr1  out  ADDR_WIDTH  SRAM port 1 read address.
- dout1  in  DATA_WIDTH  SRAM port 1 read data; valid one posedge after the SRAM captures addr1.
REQ-005 SHALL drive all outputs directly from flops.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-007 In IDLE with sample_valid=1 (cycle 0), SHALL accept the sample and latch it and delay_len; next state is ISSUE.
REQ-008 In ISSUE (cycle 1), SHALL drive the following, then go to WAIT:
- csb0=0, web0=0, addr0=wr_ptr, din0=latched sample.
- csb1=0, addr1=rd_addr, where rd_addr = (wr_ptr - delay_len) mod 2^ADDR_WIDTH.
REQ-009 In WAIT (cycle 2), SHALL drive csb0=1, web0=1, csb1=1; next state is DONE.
REQ-010 On the posedge entering DONE (start of cycle 3), SHALL register delayed_sample; delayed_valid=1 for DONE only; next state is IDLE.
REQ-011 Latency SHALL be fixed: sample_valid in cycle 0 gives delayed_valid in cycle 3; max acceptance rate 1 per 4 cycles.
REQ-012 Outside ISSUE, csb0, web0 and csb1 SHALL be 1; addr0, addr1 and din0 SHALL hold their last values.
REQ-013 wr_ptr SHALL increment by 1 mod 2^ADDR_WIDTH on leaving ISSUE; wrap 16383->0 without stall.
REQ-014 rd_addr subtraction SHALL be ADDR_WIDTH-bit modular (e.g. wr_ptr=2, delay_len=5 -> 16381).
REQ-015 fill_cnt SHALL increment per accepted sample, saturating at 2^ADDR_WIDTH-1.
REQ-016 If fill_cnt (pre-increment) < latched delay_len, delayed_sample SHALL be 0, not dout1 (uninitialised memory never propagates).
REQ-017 If latched delay_len=0, csb1 SHALL stay 1 in ISSUE, delayed_sample SHALL equal the latched sample, and latency SHALL be unchanged.
REQ-018 sample_valid while busy=1 SHALL be dropped and set overrun=1; FSM timing is unaffected.
REQ-019 sample_valid in the DONE cycle SHALL count as busy (dropped).
REQ-020 A delay_len change SHALL affect only samples accepted afterwards; wr_ptr and fill_cnt are not reset.
REQ-021 Port 0 and port 1 addresses SHALL never be equal in ISSUE (delay_len>=1 for reads), so no read/write collision occurs.

Reset
REQ-022 On wb_rst_i=1 at posedge, SHALL set:
- state=IDLE, wr_ptr=0, fill_cnt=0.
- delayed_sample=0, delayed_valid=0, busy=0, overrun=0.
- csb0=1, web0=1, csb1=1, addr0=0, addr1=0, din0=0.
REQ-023 Reset mid-operation (any state) SHALL abort: no delayed_valid issued, and any pending ISSUE strobe is deasserted the following cycle.
REQ-024 The sample_valid strobe present in a reset cycle SHALL be ignored.

Verification
REQ-025 Basic delay: delay_len=3, samples 0x0011, 0x0022, 0x0033, 0x0044, 0x0055 spaced 4 cycles -> outputs 0, 0, 0, 0x0011, 0x0022, each 3 cycles after its input.
REQ-026 Bypass: delay_len=0, sample 0x7FFF -> delayed_sample=0x7FFF in cycle 3, csb1 never 0.
REQ-027 Wrap: preload wr_ptr=16383 via 16383 samples, delay_len=2 -> addr0 16383 then 0; addr1 16381 then 16382; data correct across wrap.
REQ-028 Overrun: sample_valid in cycles 0 and 2 -> only the first is accepted, overrun=1 from cycle 3, one delayed_valid.
REQ-029 Reset mid-op: assert wb_rst_i in WAIT -> no delayed_valid; next cycle all SRAM strobes=1, wr_ptr=0, fill_cnt=0.
REQ-030 The bench SHALL check every SRAM strobe cycle against an SRAM model with a posedge capture, negedge update timing model.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// Audio delay-line controller driving a 1W/1R SRAM ring buffer.
// One sample per four-cycle transaction: accept, issue, wait for read data, present.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    output logic [DATA_WIDTH-1:0] delayed_sample,
    output logic                  delayed_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  bypass;
    logic                  not_filled;

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; the reset branch is synchronous to wb_clk_i.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            fill_cnt       <= '0;
            bypass         <= 1'b0;
            not_filled     <= 1'b0;
            delayed_sample <= '0;
            delayed_valid  <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            csb0           <= 1'b1;
            web0           <= 1'b1;
            csb1           <= 1'b1;
            addr0          <= '0;
            addr1          <= '0;
            din0           <= '0;
        end else begin
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        // delay_len is consumed here only, so later changes
                        // affect just the samples accepted after them.
                        bypass     <= (delay_len == '0);
                        not_filled <= (fill_cnt < delay_len);
                        if (fill_cnt != '1)
                            fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
                        csb0  <= 1'b0;
                        web0  <= 1'b0;
                        addr0 <= wr_ptr;
                        din0  <= sample_in;
                        csb1  <= (delay_len == '0);
                        if (delay_len != '0)
                            addr1 <= wr_ptr - delay_len;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    csb0   <= 1'b1;
                    web0   <= 1'b1;
                    csb1   <= 1'b1;
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    state  <= WAIT;
                end
                WAIT: begin
                    // din0 still holds the accepted sample, which is the bypass value.
                    if (bypass)
                        delayed_sample <= din0;
                    else if (not_filled)
                        delayed_sample <= '0;
                    else
                        delayed_sample <= dout1;
                    delayed_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    delayed_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a posedge-capture / negedge-update SRAM model.
module tb_delay_line_ctrl;

    localparam int DW = 16;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [AW-1:0] delay_len;
    logic [DW-1:0] delayed_sample;
    logic          delayed_valid;
    logic          busy;
    logic          overrun;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1 = '0;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [AW-1:0] exp_wp  = '0;
    logic [AW-1:0] exp_a1  = '0;
    logic          exp_ovr = 1'b0;

    delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (wb_rst_i),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .delay_len      (delay_len),
        .delayed_sample (delayed_sample),
        .delayed_valid  (delayed_valid),
        .busy           (busy),
        .overrun        (overrun),
        .csb0           (csb0),
        .web0           (web0),
        .addr0          (addr0),
        .din0           (din0),
        .csb1           (csb1),
        .addr1          (addr1),
        .dout1          (dout1)
    );

    always #5 clk = ~clk;

    // SRAM: ports captured at posedge, array and read data updated at the following negedge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          wr_pend = 1'b0;
    logic          rd_pend = 1'b0;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    always @(posedge clk) begin
        wr_pend <= !csb0 && !web0;
        wa      <= addr0;
        wd      <= din0;
        rd_pend <= !csb1;
        ra      <= addr1;
    end

    always @(negedge clk) begin
        if (rd_pend) dout1 <= mem[ra];
        if (wr_pend) mem[wa] <= wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dval(input int i);
        return DW'(i * 3 + 5);
    endfunction

    // One four-cycle transaction starting in IDLE; returns in the following IDLE cycle.
    task automatic send(input logic [DW-1:0] s, input logic [AW-1:0] dl,
                        input logic [DW-1:0] exp_out, input bit inj2, input bit inj3);
        logic [AW-1:0] rd;
        rd = exp_wp - dl;
        check("c0_busy", 32'(busy), 0);
        check("c0_valid", 32'(delayed_valid), 0);
        sample_in    = s;
        sample_valid = 1'b1;
        delay_len    = dl;
        step();
        sample_valid = 1'b0;
        sample_in    = 16'hDEAD;
        delay_len    = ~dl;
        if (dl != '0) exp_a1 = rd;
        check("issue_csb0", 32'(csb0), 0);
        check("issue_web0", 32'(web0), 0);
        check("issue_addr0", 32'(addr0), 32'(exp_wp));
        check("issue_din0", 32'(din0), 32'(s));
        check("issue_csb1", 32'(csb1), (dl == '0) ? 1 : 0);
        if (dl != '0) check("issue_addr1", 32'(addr1), 32'(exp_a1));
        check("issue_busy", 32'(busy), 1);
        step();
        if (inj2) begin
            sample_valid = 1'b1;
            sample_in    = 16'hBEEF;
        end
        check("wait_csb0", 32'(csb0), 1);
        check("wait_web0", 32'(web0), 1);
        check("wait_csb1", 32'(csb1), 1);
        check("wait_addr0", 32'(addr0), 32'(exp_wp));
        check("wait_din0", 32'(din0), 32'(s));
        if (dl != '0) check("wait_addr1", 32'(addr1), 32'(exp_a1));
        check("wait_valid", 32'(delayed_valid), 0);
        step();
        sample_valid = inj3;
        sample_in    = 16'hBEEF;
        check("done_valid", 32'(delayed_valid), 1);
        check("done_sample", 32'(delayed_sample), 32'(exp_out));
        check("done_overrun", 32'(overrun), 32'(exp_ovr | inj2));
        check("done_csb", 32'({csb0, web0, csb1}), 7);
        check("done_busy", 32'(busy), 1);
        step();
        sample_valid = 1'b0;
        delay_len    = dl;
        exp_ovr      = exp_ovr | inj2 | inj3;
        check("idle_valid", 32'(delayed_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_overrun", 32'(overrun), 32'(exp_ovr));
        check("idle_sample_hold", 32'(delayed_sample), 32'(exp_out));
        exp_wp = exp_wp + AW'(1);
    endtask

    task automatic do_reset();
        wb_rst_i     = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'h4321;
        step();
        step();
        wb_rst_i     = 1'b0;
        sample_valid = 1'b0;
        exp_wp  = '0;
        exp_a1  = '0;
        exp_ovr = 1'b0;
        check("rst_strobes", 32'({csb0, web0, csb1}), 7);
        check("rst_addr0", 32'(addr0), 0);
        check("rst_addr1", 32'(addr1), 0);
        check("rst_din0", 32'(din0), 0);
        check("rst_sample", 32'(delayed_sample), 0);
        check("rst_flags", 32'({delayed_valid, busy, overrun}), 0);
        step();
        check("rst_strobe_ignored", 32'(busy), 0);
    endtask

    initial begin
        wb_rst_i     = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        delay_len    = '0;
        step();
        do_reset();

        // Basic delay of 3: first three outputs come from unfilled history.
        send(16'h0011, 14'd3, 16'h0000, 0, 0);
        send(16'h0022, 14'd3, 16'h0000, 0, 0);
        send(16'h0033, 14'd3, 16'h0000, 0, 0);
        send(16'h0044, 14'd3, 16'h0011, 0, 0);
        send(16'h0055, 14'd3, 16'h0022, 0, 0);

        // Bypass at wr_ptr 5, then a strobe in DONE is dropped and flags overrun.
        send(16'h7FFF, 14'd0, 16'h7FFF, 0, 0);
        send(16'h5678, 14'd2, 16'h0055, 0, 1);

        // Reset while in WAIT: no output, strobes idle, pointers cleared.
        sample_in    = 16'h9999;
        sample_valid = 1'b1;
        delay_len    = 14'd1;
        step();
        sample_valid = 1'b0;
        check("rw_issue_csb0", 32'(csb0), 0);
        check("rw_issue_addr0", 32'(addr0), 7);
        step();
        wb_rst_i     = 1'b1;
        sample_valid = 1'b1;
        step();
        wb_rst_i     = 1'b0;
        sample_valid = 1'b0;
        check("rw_strobes", 32'({csb0, web0, csb1}), 7);
        check("rw_flags", 32'({delayed_valid, busy, overrun}), 0);
        check("rw_addr0", 32'(addr0), 0);
        check("rw_addr1", 32'(addr1), 0);
        check("rw_din0", 32'(din0), 0);
        step();
        check("rw_no_valid", 32'(delayed_valid), 0);
        exp_wp  = '0;
        exp_a1  = '0;
        exp_ovr = 1'b0;

        // Reset while in ISSUE: pending strobes drop the next cycle.
        sample_in    = 16'hAAAA;
        sample_valid = 1'b1;
        delay_len    = 14'd1;
        step();
        sample_valid = 1'b0;
        check("ri_issue_csb0", 32'(csb0), 0);
        check("ri_issue_addr0", 32'(addr0), 0);
        check("ri_issue_addr1", 32'(addr1), 16383);
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        check("ri_strobes", 32'({csb0, web0, csb1}), 7);
        check("ri_busy", 32'(busy), 0);
        step();
        check("ri_no_valid_a", 32'(delayed_valid), 0);
        step();
        check("ri_no_valid_b", 32'(delayed_valid), 0);

        // Overrun: strobe in WAIT dropped; wr_ptr advances by one only.
        send(16'h0101, 14'd1, 16'h0000, 1, 0);
        send(16'h0202, 14'd1, 16'h0101, 0, 0);

        // Wrap: 16383 samples bring wr_ptr to 16383, then two across the wrap.
        do_reset();
        for (int i = 0; i < 16383; i++)
            send(dval(i), 14'd2, (i < 2) ? 16'h0000 : dval(i - 2), 0, 0);
        send(dval(16383), 14'd2, dval(16381), 0, 0);
        send(dval(16384), 14'd2, dval(16382), 0, 0);

        // Saturated fill count allows the maximum delay: wr_ptr 1 reads address 2.
        send(16'hCAFE, 14'd16383, 16'h000B, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
